// File: rtl/comet_uart_pkg.sv
// Shared constants and types for the COMET II memory-mapped UART transmitter.
// The PARITY state exists only when COMET_UART_PARITY_EN is defined.
package comet_uart_pkg;

    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] DIVISOR_OFS = 2'd2;

    localparam int unsigned ST_BUSY_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_FULL_BIT  = 2;
    localparam int unsigned ST_OVF_BIT   = 3;
    localparam int unsigned ST_CNT_LSB   = 8;
    localparam int unsigned ST_CNT_W     = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef COMET_UART_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } tx_state_e;

    // A programmed divisor of zero behaves as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/comet_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a combinational head read.
module comet_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_c,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // Full/empty are pre-edge: a push into a full FIFO is dropped even with a concurrent pop.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_q + AW'(do_push);
            rptr_q  <= rptr_q + AW'(do_pop);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign data_c  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/comet_mmio_uart_tx.sv
// COMET II bus responder: register window feeding a TX FIFO and an 8N1 serial engine.
// Define COMET_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module comet_mmio_uart_tx
    import comet_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        mclk,
    input  logic        init,
    input  logic        re,
    input  logic [15:0] raddr,
    output logic [15:0] rdata,
    input  logic        we,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rsel, wsel, push_req, div_wr, status_rd;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, fdiv_q, fdiv_d, div_q, div_d;
    logic [15:0] rdata_q, rdata_d, status_c;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        txd_q, txd_d, irq_q, irq_d, ovf_q, ovf_d;
    logic        bit_done, load;
`ifdef COMET_UART_PARITY_EN
    logic        par_q, par_d;
`endif

    assign rsel      = (raddr[15:2] == BASE_ADDR[15:2]);
    assign wsel      = (waddr[15:2] == BASE_ADDR[15:2]);
    assign push_req  = we && wsel && (waddr[1:0] == TXDATA_OFS);
    assign div_wr    = we && wsel && (waddr[1:0] == DIVISOR_OFS);
    assign status_rd = re && rsel && (raddr[1:0] == STATUS_OFS);
    assign bit_done  = (cnt_q == 16'd0);

    comet_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mclk),
        .rst_n   (init),
        .push_i  (push_req),
        .data_i  (wdata[7:0]),
        .pop_i   (fifo_pop),
        .data_c  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register file, read mux and sticky overflow.
    always_comb begin
        status_c = '0;
        status_c[ST_BUSY_BIT]  = (state_q != S_IDLE);
        status_c[ST_EMPTY_BIT] = fifo_empty;
        status_c[ST_FULL_BIT]  = fifo_full;
        status_c[ST_OVF_BIT]   = ovf_q;
        status_c[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);

        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            if (rsel) begin
                case (raddr[1:0])
                    STATUS_OFS:  rdata_d = status_c;
                    DIVISOR_OFS: rdata_d = div_q;
                    default:     rdata_d = '0;
                endcase
            end
        end

        // An overflow on the same edge as the clearing read wins.
        ovf_d = ovf_q;
        if (status_rd) ovf_d = 1'b0;
        if (push_req && fifo_full) ovf_d = 1'b1;

        div_d = div_wr ? wdata : div_q;
        irq_d = (state_q == S_IDLE) && fifo_empty;
    end

    // Transmit engine next-state; txd is registered from the next-state view.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fdiv_d   = fdiv_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        txd_d    = 1'b1;
`ifdef COMET_UART_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            S_IDLE:  load = !fifo_empty;
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef COMET_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef COMET_UART_PARITY_EN
            S_PARITY: if (bit_done) state_d = S_STOP;
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? (fdiv_q - 16'd1) : (cnt_q - 16'd1);
        end

        // Frame start: pop the byte and freeze the divisor for the whole frame.
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = S_START;
            shift_d  = fifo_head;
            fdiv_d   = eff_div(div_q);
            cnt_d    = fdiv_d - 16'd1;
`ifdef COMET_UART_PARITY_EN
            par_d    = ^fifo_head;
`endif
        end

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef COMET_UART_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge mclk or negedge init) begin
        if (!init) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            fdiv_q  <= 16'd1;
            div_q   <= DEFAULT_DIV;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
`ifdef COMET_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            fdiv_q  <= fdiv_d;
            div_q   <= div_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            txd_q   <= txd_d;
            irq_q   <= irq_d;
`ifdef COMET_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign txd   = txd_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_comet_mmio_uart_tx.sv
// Self-checking bench for comet_mmio_uart_tx: register-access vector table,
// waveform-level frame model with random bytes/divisors, and multi-cycle corner sequences.
module tb_comet_mmio_uart_tx;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DEPTH = 16;
`ifdef COMET_UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic        mclk = 1'b0;
    logic        init = 1'b0;
    logic        re = 1'b0, we = 1'b0;
    logic [15:0] raddr = '0, waddr = '0, wdata = '0;
    logic [15:0] rdata;
    logic        txd, irq;

    int errs = 0;
    int checks = 0;

    logic [7:0] bq[$];
    bit         wave[$];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 mclk = ~mclk;

    comet_mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .mclk  (mclk),
        .init  (init),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .txd   (txd),
        .irq   (irq)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        waddr = addr;
        wdata = data;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] d);
        raddr = addr;
        re    = 1'b1;
        tick();
        re    = 1'b0;
        d     = rdata;
    endtask

    // Expected line levels for one frame, one entry per clock cycle.
    task automatic push_frame(input logic [7:0] b, input int div);
        int e;
        int ones;
        e = (div == 0) ? 1 : div;
        ones = 0;
        for (int c = 0; c < e; c++) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < e; c++) wave.push_back(b[i]);
            ones += int'(b[i]);
        end
        for (int p = 0; p < PAR_BITS; p++)
            for (int c = 0; c < e; c++) wave.push_back(ones % 2 == 1);
        for (int c = 0; c < e; c++) wave.push_back(1'b1);
    endtask

    // Send the bytes in bq back-to-back at the given divisor and check txd/irq/BUSY per cycle.
    task automatic send_and_check(input int div, input string tag);
        int nb;
        int len;
        nb = bq.size();
        wave.delete();
        foreach (bq[i]) push_frame(bq[i], div);
        len = wave.size();
        bus_write(BASE + 16'd2, 16'(div));
        raddr = BASE + 16'd1;
        re    = 1'b1;
        bus_write(BASE, {8'h00, bq[0]});
        for (int k = 1; k <= len + 2; k++) begin
            if (k < nb) begin
                we = 1'b1; waddr = BASE; wdata = {8'h00, bq[k]};
            end else begin
                we = 1'b0;
            end
            tick();
            if (k <= len) chk($sformatf("%s txd k=%0d", tag, k), 16'(txd), 16'(wave[k-1]));
            else          chk($sformatf("%s txd idle k=%0d", tag, k), 16'(txd), 16'd1);
            chk($sformatf("%s irq k=%0d", tag, k), 16'(irq), 16'(k == len + 2));
            chk($sformatf("%s busy k=%0d", tag, k), 16'(rdata[0]), 16'(k >= 2 && k <= len + 1));
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int          cnt;
        bit          ovf;
        logic [15:0] st;

        repeat (3) tick();
        chk("reset txd", 16'(txd), 16'd1);
        chk("reset irq", 16'(irq), 16'd1);
        chk("reset rdata", rdata, 16'h0000);
        init = 1'b1;
        tick();

        vecs.push_back('{0, BASE + 16'd1, 16'h0000, 16'h0002});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0010});
        vecs.push_back('{0, BASE + 16'd0, 16'h0000, 16'h0000});
        vecs.push_back('{0, BASE + 16'd3, 16'h0000, 16'h0000});
        vecs.push_back('{0, 16'h0100,     16'h0000, 16'h0000});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0010});
        vecs.push_back('{1, BASE + 16'd3, 16'hFFFF, 16'h0010});
        vecs.push_back('{1, BASE + 16'd1, 16'hFFFF, 16'h0010});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0010});
        vecs.push_back('{0, BASE + 16'd1, 16'h0000, 16'h0002});
        vecs.push_back('{0, 16'hFF04,     16'h0000, 16'h0000});
        vecs.push_back('{1, 16'hFF06,     16'h0001, 16'h0000});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0010});
        vecs.push_back('{1, BASE + 16'd2, 16'h0000, 16'h0010});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0000});
        vecs.push_back('{1, BASE + 16'd2, 16'h0004, 16'h0000});
        vecs.push_back('{0, BASE + 16'd2, 16'h0000, 16'h0004});
        vecs.push_back('{0, 16'h0100,     16'h0000, 16'h0000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
                chk($sformatf("vec%0d held rdata", i), rdata, vecs[i].exp);
            end else begin
                bus_read(vecs[i].addr, d);
                chk($sformatf("vec%0d read %h", i, vecs[i].addr), d, vecs[i].exp);
            end
        end
        chk("idle txd after regs", 16'(txd), 16'd1);
        chk("idle irq after regs", 16'(irq), 16'd1);

        bq.delete(); bq.push_back(8'h55);
        send_and_check(4, "f55");
        bq.delete(); bq.push_back(8'h3C); bq.push_back(8'hC3);
        send_and_check(3, "b2b");
        bq.delete(); bq.push_back(8'h80);
        send_and_check(0, "div0");
        for (int it = 0; it < 6; it++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            bq.delete();
            for (int j = 0; j < nb; j++) bq.push_back(8'($urandom_range(0, 255)));
            send_and_check(int'($urandom_range(0, 5)), $sformatf("rnd%0d", it));
        end

        // Overflow: engine busy on a long frame, then 17 back-to-back pushes.
        bus_write(BASE + 16'd2, 16'd1000);
        bus_write(BASE, 16'h00A5);
        repeat (3) tick();
        cnt = 0;
        ovf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_write(BASE, 16'(i));
            if (cnt < DEPTH) cnt++;
            else             ovf = 1'b1;
        end
        st = {1'b0, 7'(cnt), 4'h0, ovf, cnt == DEPTH, cnt == 0, 1'b1};
        bus_read(BASE + 16'd1, d);
        chk("ovf status", d, st);
        st[3] = 1'b0;
        bus_read(BASE + 16'd1, d);
        chk("ovf cleared", d, st);
        raddr = BASE + 16'd1; re = 1'b1;
        waddr = BASE; wdata = 16'h0077; we = 1'b1;
        tick();
        re = 1'b0; we = 1'b0;
        chk("ovf same-edge read", rdata, st);
        st[3] = 1'b1;
        bus_read(BASE + 16'd1, d);
        chk("ovf set wins", d, st);
        chk("long start bit", 16'(txd), 16'd0);
        init = 1'b0;
        #2;
        chk("async reset txd", 16'(txd), 16'd1);
        chk("async reset irq", 16'(irq), 16'd1);
        chk("async reset rdata", rdata, 16'h0000);
        @(negedge mclk);
        init = 1'b1;
        tick();
        bus_read(BASE + 16'd1, d);
        chk("status after reset", d, 16'h0002);
        bus_read(BASE + 16'd2, d);
        chk("divisor after reset", d, 16'd16);

        // Reset during the data bits with a second byte still queued.
        bus_write(BASE + 16'd2, 16'd4);
        bus_write(BASE, 16'h0000);
        bus_write(BASE, 16'h0000);
        repeat (6) tick();
        chk("mid-data txd", 16'(txd), 16'd0);
        init = 1'b0;
        #2;
        chk("mid-data reset txd", 16'(txd), 16'd1);
        @(negedge mclk);
        init = 1'b1;
        tick();
        bus_read(BASE + 16'd1, d);
        chk("mid-data status", d, 16'h0002);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("post-reset idle txd %0d", k), 16'(txd), 16'd1);
        end
        chk("post-reset irq", 16'(irq), 16'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
